// File: rtl/xor_unit_arbiter.sv
// xor_unit_arbiter: shares one N-bit BitWiseXOR datapath among R requesters using
// work-conserving round-robin arbitration. The winner's a^b is registered together with
// its requester ID and offered on a single valid/ready response port.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   req_valid_i   [R]    per-requester operand pair valid
//   req_ready_o   [R]    per-requester accept (one-hot or zero)
//   req_a_i       [R*N]  operand A, requester i at [i*N +: N]
//   req_b_i       [R*N]  operand B, requester i at [i*N +: N]
//   rsp_valid_o          result valid
//   rsp_ready_i          downstream accept
//   rsp_c_o       [N]    registered a^b of the granted requester
//   rsp_id_o      [IDW]  index of the requester that produced rsp_c_o
//   xfer_count_o  [CW]   completed response handshakes, wraps

module BitWiseXOR #(
  parameter int N     = 32,
  parameter     MODEL = "Structural"
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] c_o
);

  if (MODEL == "Behavioral") begin : g_behavioral
    always_comb begin
      c_o = '0;
      for (int i = 0; i < N; i++) begin
        c_o[i] = a_i[i] ^ b_i[i];
      end
    end
  end else if (MODEL == "DataFlow") begin : g_dataflow
    assign c_o = a_i ^ b_i;
  end else begin : g_structural
    for (genvar g = 0; g < N; g++) begin : g_bit
      assign c_o[g] = (a_i[g] & ~b_i[g]) | (~a_i[g] & b_i[g]);
    end
  end

endmodule

module xor_unit_arbiter #(
  parameter int N     = 32,
  parameter int R     = 4,
  parameter     MODEL = "Structural",
  parameter int CW    = 16,
  localparam int IDW  = $clog2(R)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [R-1:0]   req_valid_i,
  output logic [R-1:0]   req_ready_o,
  input  logic [R*N-1:0] req_a_i,
  input  logic [R*N-1:0] req_b_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [N-1:0]   rsp_c_o,
  output logic [IDW-1:0] rsp_id_o,
  output logic [CW-1:0]  xfer_count_o
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   rsp_c_q, rsp_c_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [CW-1:0]  count_q, count_d;

  logic           can_accept;
  logic           handshake;
  logic           found;
  logic           grant;
  logic [IDW-1:0] win;
  logic [N-1:0]   a_sel, b_sel, xor_out;

  assign rsp_valid_o  = (state_q == StFull);
  assign handshake    = rsp_valid_o & rsp_ready_i;
  assign can_accept   = (state_q == StEmpty) | handshake;
  assign rsp_c_o      = rsp_c_q;
  assign rsp_id_o     = rsp_id_q;
  assign xfer_count_o = count_q;

  // Winner is the valid requester with the smallest rotated distance from ptr_q.
  always_comb begin
    int best_d;
    int d;
    best_d = R;
    d      = 0;
    win    = '0;
    for (int i = 0; i < R; i++) begin
      if (req_valid_i[i]) begin
        d = (i + R - int'(ptr_q)) % R;
        if (d < best_d) begin
          best_d = d;
          win    = IDW'(i);
        end
      end
    end
    found = (best_d < R);
  end

  assign grant = found & can_accept;

  always_comb begin
    req_ready_o = '0;
    a_sel       = '0;
    b_sel       = '0;
    for (int i = 0; i < R; i++) begin
      req_ready_o[i] = grant && (win == IDW'(i));
      if (win == IDW'(i)) begin
        a_sel = req_a_i[i*N +: N];
        b_sel = req_b_i[i*N +: N];
      end
    end
  end

  BitWiseXOR #(
    .N     (N),
    .MODEL (MODEL)
  ) u_xor (
    .a_i (a_sel),
    .b_i (b_sel),
    .c_o (xor_out)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rsp_c_d  = rsp_c_q;
    rsp_id_d = rsp_id_q;
    count_d  = count_q;
    if (handshake) begin
      count_d = count_q + CW'(1);
    end
    if (grant) begin
      state_d  = StFull;
      rsp_c_d  = xor_out;
      rsp_id_d = win;
      ptr_d    = (win == IDW'(R - 1)) ? '0 : win + IDW'(1);
    end else if (handshake) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StEmpty;
      ptr_q    <= '0;
      rsp_c_q  <= '0;
      rsp_id_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rsp_c_q  <= rsp_c_d;
      rsp_id_q <= rsp_id_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Bench for xor_unit_arbiter: three instances (one per XOR model, CW=4) share stimulus and
// are checked every cycle against a queue-free behavioural model, plus directed scenarios
// with literal expectations.

module tb_xor_unit_arbiter;

  localparam int N  = 32;
  localparam int R  = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [R-1:0]   req_valid = '0;
  logic [R*N-1:0] req_a = '0;
  logic [R*N-1:0] req_b = '0;
  logic           rsp_ready = 1'b0;

  logic [R-1:0]  rdy [3];
  logic          vld [3];
  logic [N-1:0]  rc  [3];
  logic [1:0]    rid [3];
  logic [CW-1:0] cnt [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_unit_arbiter #(.N(N), .R(R), .MODEL("Structural"), .CW(CW)) u_dut_s (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
    .req_a_i(req_a), .req_b_i(req_b), .rsp_valid_o(vld[0]), .rsp_ready_i(rsp_ready),
    .rsp_c_o(rc[0]), .rsp_id_o(rid[0]), .xfer_count_o(cnt[0])
  );
  xor_unit_arbiter #(.N(N), .R(R), .MODEL("Behavioral"), .CW(CW)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
    .req_a_i(req_a), .req_b_i(req_b), .rsp_valid_o(vld[1]), .rsp_ready_i(rsp_ready),
    .rsp_c_o(rc[1]), .rsp_id_o(rid[1]), .xfer_count_o(cnt[1])
  );
  xor_unit_arbiter #(.N(N), .R(R), .MODEL("DataFlow"), .CW(CW)) u_dut_d (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy[2]),
    .req_a_i(req_a), .req_b_i(req_b), .rsp_valid_o(vld[2]), .rsp_ready_i(rsp_ready),
    .rsp_c_o(rc[2]), .rsp_id_o(rid[2]), .xfer_count_o(cnt[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr;
  bit          m_full;
  logic [31:0] m_c;
  int          m_id;
  int          m_cnt;

  // First valid requester in order ptr, ptr+1, ... (mod R), or -1.
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < R; k++) begin
      int j;
      j = (p + k) % R;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    w = pick(req_valid, m_ptr);
    if ((!m_full || rsp_ready) && w >= 0) return 4'b0001 << w;
    return 4'b0000;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_full = 0; m_c = '0; m_id = 0; m_cnt = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else begin
        int  w;
        bit  hs;
        w  = pick(req_valid, m_ptr);
        hs = m_full && rsp_ready;
        if (hs) m_cnt = (m_cnt + 1) % (1 << CW);
        if ((!m_full || rsp_ready) && w >= 0) begin
          m_full = 1;
          m_c    = req_a[w*N +: N] ^ req_b[w*N +: N];
          m_id   = w;
          m_ptr  = (w + 1) % R;
        end else if (hs) begin
          m_full = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("m%0d_valid", m), 32'(vld[m]), 32'(m_full));
        chk($sformatf("m%0d_c", m), rc[m], m_c);
        chk($sformatf("m%0d_id", m), 32'(rid[m]), 32'(m_id));
        chk($sformatf("m%0d_count", m), 32'(cnt[m]), 32'(m_cnt));
        chk($sformatf("m%0d_ready", m), 32'(rdy[m]), 32'(exp_ready()));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] hold_c;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Single request: literal XOR result and handshake count.
    req_a[31:0] = 32'hFFFF0000;
    req_b[31:0] = 32'h0F0F0F0F;
    req_valid   = 4'b0001;
    rsp_ready   = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("single_ready", 32'(rdy[m]), 32'h1);
      chk("single_idle", 32'(vld[m]), 32'h0);
    end
    step();
    req_valid = 4'b0000;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("single_valid", 32'(vld[m]), 32'h1);
      chk("single_c", rc[m], 32'hF0F00F0F);
      chk("single_id", 32'(rid[m]), 32'h0);
      chk("single_cnt0", 32'(cnt[m]), 32'h0);
    end
    step();
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("single_cnt1", 32'(cnt[m]), 32'h1);
      chk("single_empty", 32'(vld[m]), 32'h0);
    end

    // Reset with a result in flight.
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    step();
    #1;
    for (int m = 0; m < 3; m++) chk("pre_rst_valid", 32'(vld[m]), 32'h1);
    rst = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("rst_valid", 32'(vld[m]), 32'h0);
      chk("rst_c", rc[m], 32'h0);
      chk("rst_id", 32'(rid[m]), 32'h0);
      chk("rst_cnt", 32'(cnt[m]), 32'h0);
    end
    step();
    rst       = 1'b0;
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;

    // All contending: grants 0,1,2,3,0,1 with no idle cycles.
    for (int k = 0; k < 6; k++) begin
      for (int m = 0; m < 3; m++) begin
        chk("rr_ready", 32'(rdy[m]), 32'(4'b0001 << (k % 4)));
        if (k > 0) begin
          chk("rr_id", 32'(rid[m]), 32'((k - 1) % 4));
          chk("rr_valid", 32'(vld[m]), 32'h1);
        end
      end
      step();
      #1;
    end
    for (int m = 0; m < 3; m++) chk("rr_last_id", 32'(rid[m]), 32'h1);

    // Backpressure: outputs frozen, no grant.
    hold_c    = req_a[1*N +: N] ^ req_b[1*N +: N];
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    repeat (5) begin
      #1;
      for (int m = 0; m < 3; m++) begin
        chk("bp_ready", 32'(rdy[m]), 32'h0);
        chk("bp_valid", 32'(vld[m]), 32'h1);
        chk("bp_id", 32'(rid[m]), 32'h1);
        chk("bp_c", rc[m], hold_c);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) chk("bp_release_ready", 32'(rdy[m]), 32'h4);
    step();
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("bp_next_id", 32'(rid[m]), 32'h2);
      chk("bp_next_valid", 32'(vld[m]), 32'h1);
      chk("bp_cnt", 32'(cnt[m]), 32'h6);
    end

    // Fairness skip from ptr=1 with only req3 and req0 valid.
    rst = 1'b1;
    #1 rst = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1001;
    #1;
    for (int m = 0; m < 3; m++) chk("skip_ready3", 32'(rdy[m]), 32'h8);
    step();
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("skip_id3", 32'(rid[m]), 32'h3);
      chk("skip_ready0", 32'(rdy[m]), 32'h1);
    end
    step();
    req_valid = 4'b1111;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("skip_id0", 32'(rid[m]), 32'h0);
      chk("skip_ptr1", 32'(rdy[m]), 32'h2);
    end

    // Counter wrap: 17 handshakes on a 4-bit counter.
    rst = 1'b1;
    #1 rst = 1'b0;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    repeat (18) step();
    #1;
    for (int m = 0; m < 3; m++) chk("wrap_cnt", 32'(cnt[m]), 32'h1);

    // Randomized traffic, checked by the model.
    repeat (3000) begin
      step();
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_a     = {$urandom, $urandom, $urandom, $urandom};
      req_b     = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
